// File: rtl/div_pkg.sv
// Shared types and constants for the iterative signed divider.
// Holds the FSM state encoding and the signed range helpers.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DIV_W     = 20;
   localparam int DIV_CNT_W = 5;

   // Largest positive value of a w-bit two's-complement number.
   function automatic logic [63:0] smax(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   // Bit pattern of the most negative w-bit two's-complement number.
   function automatic logic [63:0] smin(input int w);
      return 64'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
// The partial remainder carries one spare bit so the compare never wraps.
module div_restore_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic [WIDTH:0]   i_prem,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_dsr,
   output logic [WIDTH:0]   o_prem,
   output logic             o_qbit
);

   logic [WIDTH+1:0] w_shift;
   logic [WIDTH+1:0] w_dsr_ext;
   logic [WIDTH+1:0] w_diff;

   assign w_shift   = {i_prem, i_bit};
   assign w_dsr_ext = {2'b00, i_dsr};
   assign w_diff    = w_shift - w_dsr_ext;
   assign o_qbit    = (w_shift >= w_dsr_ext);
   assign o_prem    = (WIDTH + 1)'(o_qbit ? w_diff : w_shift);

endmodule

// File: rtl/signed_div_20b_seq.sv
// Iterative signed restoring divider with valid/ready handshake.
// Quotient and remainder truncate toward zero; remainder follows dividend sign.
module signed_div_20b_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_W,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] dividend,
   input  logic signed [WIDTH-1:0] divisor,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] quotient,
   output logic signed [WIDTH-1:0] remainder,
   output logic                    div_by_zero,
   output logic                    overflow
);

   localparam logic [WIDTH-1:0] C_SMAX = WIDTH'(smax(WIDTH));
   localparam logic [WIDTH-1:0] C_SMIN = WIDTH'(smin(WIDTH));
   localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_in_ready;
   logic                    r_out_valid;
   logic signed [WIDTH-1:0] r_quot;
   logic signed [WIDTH-1:0] r_rem;
   logic                    r_dz;
   logic                    r_ov;

   logic [WIDTH-1:0]        r_dvd;
   logic [WIDTH-1:0]        r_dsr;
   logic [WIDTH-1:0]        r_quo;
   logic [WIDTH:0]          r_prem;
   logic                    r_neg_q;
   logic                    r_neg_r;

   logic [WIDTH-1:0]        w_dvd_u;
   logic [WIDTH-1:0]        w_dsr_u;
   logic [WIDTH-1:0]        w_dvd_abs;
   logic [WIDTH-1:0]        w_dsr_abs;
   logic                    w_accept;
   logic                    w_div0;
   logic                    w_ovf;
   logic [WIDTH:0]          w_prem_nxt;
   logic                    w_qbit;
   logic [WIDTH-1:0]        w_quo_fix;
   logic [WIDTH-1:0]        w_rem_fix;

   assign w_dvd_u   = dividend;
   assign w_dsr_u   = divisor;
   // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct magnitude.
   assign w_dvd_abs = dividend[WIDTH-1] ? (~w_dvd_u + C_ONE) : w_dvd_u;
   assign w_dsr_abs = divisor[WIDTH-1]  ? (~w_dsr_u + C_ONE) : w_dsr_u;
   assign w_accept  = in_valid && r_in_ready && (r_state == IDLE);
   assign w_div0    = (w_dsr_u == '0);
   assign w_ovf     = (w_dvd_u == C_SMIN) && (w_dsr_u == '1);
   assign w_quo_fix = r_neg_q ? (~r_quo + C_ONE) : r_quo;
   assign w_rem_fix = r_neg_r ? (~r_prem[WIDTH-1:0] + C_ONE) : r_prem[WIDTH-1:0];

   div_restore_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_prem (r_prem),
      .i_bit  (r_dvd[WIDTH-1]),
      .i_dsr  (r_dsr),
      .o_prem (w_prem_nxt),
      .o_qbit (w_qbit)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_quot      <= '0;
         r_rem       <= '0;
         r_dz        <= 1'b0;
         r_ov        <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_in_ready <= 1'b0;
                  r_dz       <= 1'b0;
                  r_ov       <= 1'b0;
                  if (w_div0) begin
                     r_state <= DONE;
                     r_quot  <= dividend[WIDTH-1] ? C_SMIN : C_SMAX;
                     r_rem   <= dividend;
                     r_dz    <= 1'b1;
                  end else if (w_ovf) begin
                     r_state <= DONE;
                     r_quot  <= C_SMAX;
                     r_rem   <= '0;
                     r_ov    <= 1'b1;
                  end else begin
                     r_state <= CALC;
                     r_cnt   <= CNT_W'(WIDTH - 1);
                  end
               end
            end
            CALC: begin
               if (r_cnt == '0) r_state <= FIX;
               else             r_cnt   <= r_cnt - CNT_W'(1);
            end
            FIX: begin
               r_quot      <= w_quo_fix;
               r_rem       <= w_rem_fix;
               r_out_valid <= 1'b1;
               r_state     <= DONE;
            end
            DONE: begin
               // Special cases enter DONE straight from IDLE and raise out_valid one edge later.
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_dvd   <= w_dvd_abs;
         r_dsr   <= w_dsr_abs;
         r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         r_neg_r <= dividend[WIDTH-1];
         r_prem  <= '0;
         r_quo   <= '0;
      end else if (r_state == CALC) begin
         r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
         r_prem <= w_prem_nxt;
         r_quo  <= {r_quo[WIDTH-2:0], w_qbit};
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign quotient    = r_quot;
   assign remainder   = r_rem;
   assign div_by_zero = r_dz;
   assign overflow    = r_ov;

endmodule

// File: doc/signed_div_20b_seq.md
Name: signed_div_20b_seq

Overview:
- Iterative radix-2 restoring divider for 20-bit signed operands.
- Consumes the sign-extended 20-bit values produced by the signed_to_20b_signed widening stage.
- Used by the ray tracer for perspective/normalisation divides.
- Produces a signed quotient and remainder, truncated toward zero, behind a valid/ready handshake.

Parameters:
WIDTH, 20, operand/result width in bits; must be >= 4
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active low
in_valid  input  1  operands present on dividend/divisor
in_ready  output  1  block can accept operands (high only in IDLE)
dividend  input  WIDTH  signed two's-complement dividend
divisor  input  WIDTH  signed two's-complement divisor
out_valid  output  1  result present; held until out_ready
out_ready  input  1  consumer accepts result
quotient  output  WIDTH  signed quotient, truncated toward zero
remainder  output  WIDTH  signed remainder; sign follows dividend; |r| < |divisor|
div_by_zero  output  1  result flag: divisor was 0
overflow  output  1  result flag: dividend = -2^(WIDTH-1) and divisor = -1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, counter=0.
- Reset mid-operation: abandons the current division immediately; no result is produced.
- Accept: on an edge with in_valid && in_ready, the block
  - latches the operand signs, |dividend| and |divisor| as WIDTH-bit unsigned values (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits);
  - clears the partial remainder;
  - sets counter=WIDTH-1;
  - drops in_ready.
- States:
  - IDLE: in_ready=1.
    - Accept with divisor==0 -> DONE.
    - Accept with dividend==-2^(WIDTH-1) and divisor==-1 -> DONE.
    - Any other accept -> CALC.
  - CALC: one restoring step per cycle.
    - Shift the next dividend MSB into the partial remainder, compare against |divisor|, subtract if >=, shift the result bit into the quotient.
    - Partial remainder is WIDTH+1 bits wide, so the compare cannot overflow.
    - After the step with counter==0 -> FIX. Otherwise decrement counter.
  - FIX: apply signs.
    - Quotient is negated if the operand signs differ.
    - Remainder is negated if the dividend is negative.
    - Register the outputs, set out_valid=1 -> DONE.
  - DONE: out_valid=1; outputs stable.
    - On out_valid && out_ready -> IDLE; out_valid=0 and in_ready=1 on the next cycle.
- Latency, normal path: accept at edge k; CALC occupies edges k+1..k+WIDTH; FIX at edge k+WIDTH+1; out_valid first high after edge k+WIDTH+1 (WIDTH+1 cycles).
- Latency, special cases: out_valid high after edge k+1.
- Divide by zero: quotient = dividend>=0 ? 2^(WIDTH-1)-1 : -2^(WIDTH-1); remainder = dividend; div_by_zero=1.
- Overflow: quotient = 2^(WIDTH-1)-1; remainder=0; overflow=1.
- Flags are cleared on every accept and are valid only while out_valid=1.
- Backpressure: with out_ready low, DONE holds indefinitely and all outputs stay frozen.
- No accept while busy: in_ready=0 in CALC, FIX and DONE; in_valid is ignored there.
- No bypass: a new accept cannot occur in the same cycle as the result handshake. Minimum issue interval is WIDTH+3 cycles.
- Zero dividend: quotient=0, remainder=0, normal latency.

Decomposition:
- Package div_pkg:
  - state enum: IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3;
  - localparams DIV_W=20, DIV_CNT_W=5;
  - SMAX/SMIN constant functions of width.
- Sub-module div_restore_step (combinational, parameter WIDTH).
  - Inputs: partial remainder, next dividend bit, |divisor|.
  - Outputs: next partial remainder, quotient bit.
  - Lets the step be verified standalone.

Test Plan:
1. 100 / 7 -> quotient=14, remainder=2, flags 0; out_valid exactly 21 cycles after the accept edge.
2. -100/7 -> q=-14, r=-2. 100/-7 -> q=-14, r=2. -100/-7 -> q=14, r=-2. Cover all sign combinations back-to-back.
3. 12345 / 0 -> q=524287, r=12345, div_by_zero=1, out_valid 1 cycle after accept. Then -5 / 0 -> q=-524288, r=-5.
4. -524288 / -1 -> q=524287, r=0, overflow=1. Also -524288 / 1 -> q=-524288, r=0, normal latency, no flag.
5. Hold out_ready=0 for 50 cycles after 1000 / 3: q=333, r=1 stable throughout, in_ready=0. Pulse out_ready -> next cycle in_ready=1, out_valid=0.
6. Assert rst_n=0 for 1 cycle at CALC cycle 10 of 50000 / 9: next cycle state IDLE, in_ready=1, out_valid=0, all outputs 0. Then 50000 / 9 -> q=5555, r=5.
